nes_pad_reader: RTL

Parametrised serial game-pad reader. Drives the shared latch/pulse lines of one or more NES- or SNES-style controllers, shifts in every pad's serial data in parallel, and presents registered active-high button states. Also reports per-button pressed/released events and a one-cycle frame-valid strobe. Sits between the controller port pins and the game logic and LED/debug displays.

---
 rtl/nes_pad_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/nes_pad_reader.sv
// Serial NES/SNES game-pad reader: drives the shared latch/pulse lines, shifts in every
// pad in parallel and presents registered button states with pressed/released strobes.
module nes_pad_reader #(
  parameter int CLK_DIV  = 4,
  parameter int NUM_BITS = 8,
  parameter int NUM_PADS = 1,
  parameter int POLL_GAP = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_PADS-1:0]          From_Controller,
  output logic                         latch,
  output logic                         pulse,
  output logic [NUM_PADS*NUM_BITS-1:0] Buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         valid
);

  localparam int LATCH_LEN = 2 * CLK_DIV;
  localparam int TMAX      = (LATCH_LEN > POLL_GAP) ? LATCH_LEN : POLL_GAP;
  localparam int TW        = $clog2(TMAX + 1);
  localparam int BW        = $clog2(NUM_BITS + 1);
  localparam int FW        = NUM_PADS * NUM_BITS;

  localparam logic [TW-1:0] GAP_END   = TW'(POLL_GAP - 1);
  localparam logic [TW-1:0] LATCH_END = TW'(LATCH_LEN - 1);
  localparam logic [TW-1:0] HALF_END  = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {IDLE, LATCH, PULSE_HI, PULSE_LO, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [BW-1:0] bit_idx;
  logic [FW-1:0] shift_q;
  logic [FW-1:0] shift_d;

  // Each pad's slice shifts right with the new (inverted) bit entering at the MSB,
  // so after NUM_BITS samples bit 0 of the frame sits at index 0.
  always_comb begin
    shift_d = shift_q;
    for (int p = 0; p < NUM_PADS; p++) begin
      shift_d[p*NUM_BITS +: NUM_BITS] = {~From_Controller[p], shift_q[p*NUM_BITS+1 +: NUM_BITS-1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      latch    <= 1'b0;
      pulse    <= 1'b0;
      valid    <= 1'b0;
      shift_q  <= '0;
      Buttons  <= '0;
      pressed  <= '0;
      released <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Count saturates at terminal while enable is low, so a late enable starts at once.
          if (timer == GAP_END) begin
            if (enable) begin
              state <= LATCH;
              timer <= '0;
              latch <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        LATCH: begin
          if (timer == LATCH_END) begin
            shift_q <= shift_d;
            state   <= PULSE_HI;
            timer   <= '0;
            latch   <= 1'b0;
            pulse   <= 1'b1;
            bit_idx <= BW'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        PULSE_HI: begin
          if (timer == HALF_END) begin
            state <= PULSE_LO;
            timer <= '0;
            pulse <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        PULSE_LO: begin
          if (timer == HALF_END) begin
            shift_q <= shift_d;
            timer   <= '0;
            if (bit_idx == LAST_BIT) begin
              state    <= DONE;
              valid    <= 1'b1;
              Buttons  <= shift_d;
              pressed  <= shift_d & ~Buttons;
              released <= ~shift_d & Buttons;
            end else begin
              state   <= PULSE_HI;
              pulse   <= 1'b1;
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          timer    <= '0;
          valid    <= 1'b0;
          pressed  <= '0;
          released <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
